frame_tx_101: RTL



---
 rtl/frame_tx_101_pkg.sv | 16 +
 rtl/frame_tx_101_stuffer.sv | 28 ++
 rtl/frame_tx_101.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/frame_tx_101_pkg.sv
// Shared types and constants for the "101" framing transmitter.
// Optional parity feature is enabled with `define FRAME_TX_PARITY_EN.
package frame_tx_101_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      PAR,
      GAP
   } state_t;

   localparam logic [2:0]  HDR_PATTERN = 3'b101;
   localparam int unsigned GAP_LEN     = 2;

endpackage

// File: rtl/frame_tx_101_stuffer.sv
// Zero-stuff decision for the framing transmitter: tracks the last two line
// bits and forces a 0 ahead of any payload/parity bit that follows "10".
module frame_tx_101_stuffer (
   input  logic clk,
   input  logic rst,
   input  logic cand,
   input  logic eligible,
   output logic line_bit,
   output logic stuff
);

   // {older, newer} line bits, including header, idle and gap bits
   logic [1:0] last2;

   always_comb begin
      stuff    = eligible && (last2 == 2'b10);
      line_bit = stuff ? 1'b0 : cand;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last2 <= '0;
      end else begin
         last2 <= {last2[0], line_bit};
      end
   end

endmodule

// File: rtl/frame_tx_101.sv
// Serial framing transmitter: header 101, stuffed MSB-first payload, 2-bit gap.
// Define FRAME_TX_PARITY_EN to append a stuffable even-parity bit after the payload.
module frame_tx_101 #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx_bit,
   output logic              tx_active,
   output logic              tx_stuff
);

   import frame_tx_101_pkg::*;

   localparam int unsigned      CNT_W    = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] PAY_DONE = CNT_W'(DATA_W);

   state_t              state, nstate;
   logic [1:0]          hcnt, nhcnt;
   logic [1:0]          gcnt, ngcnt;
   logic [CNT_W-1:0]    sent, nsent;
   logic [DATA_W-1:0]   sreg, nsreg;
   logic                accept;
   logic                cand, eligible, active_next;
   logic                line_bit, stuff;
`ifdef FRAME_TX_PARITY_EN
   logic                par;
`endif

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;

   // Registers describe the bit currently on the line; comb logic picks the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hcnt      <= '0;
         gcnt      <= '0;
         sent      <= '0;
         sreg      <= '0;
         tx_bit    <= 1'b0;
         tx_active <= 1'b0;
         tx_stuff  <= 1'b0;
      end else begin
         state     <= nstate;
         hcnt      <= nhcnt;
         gcnt      <= ngcnt;
         sent      <= nsent;
         sreg      <= nsreg;
         tx_bit    <= line_bit;
         tx_active <= active_next;
         tx_stuff  <= stuff;
      end
   end

`ifdef FRAME_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par <= 1'b0;
      end else if (accept) begin
         par <= ^in_data;
      end
   end
`endif

   always_comb begin
      nstate = state;
      nhcnt  = hcnt;
      ngcnt  = gcnt;
      nsent  = sent;
      nsreg  = sreg;
      case (state)
         IDLE: begin
            if (accept) begin
               nstate = HDR;
               nhcnt  = '0;
               nsent  = '0;
               nsreg  = in_data;
            end
         end
         HDR, DATA: begin
            if (state == HDR && hcnt != 2'd2) begin
               nhcnt = hcnt + 2'd1;
            end else if (state == DATA && sent == PAY_DONE) begin
`ifdef FRAME_TX_PARITY_EN
               nstate = PAR;
               if (!stuff) nsent = sent + CNT_W'(1);
`else
               nstate = GAP;
               ngcnt  = '0;
`endif
            end else begin
               // a stuff bit holds the payload position
               nstate = DATA;
               if (!stuff) begin
                  nsreg = {sreg[DATA_W-2:0], 1'b0};
                  nsent = sent + CNT_W'(1);
               end
            end
         end
`ifdef FRAME_TX_PARITY_EN
         PAR: begin
            if (sent == PAY_DONE) begin
               if (!stuff) nsent = sent + CNT_W'(1);
            end else begin
               nstate = GAP;
               ngcnt  = '0;
            end
         end
`endif
         GAP: begin
            if (gcnt == 2'(GAP_LEN - 1)) begin
               nstate = IDLE;
            end else begin
               ngcnt = gcnt + 2'd1;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      cand     = 1'b0;
      eligible = 1'b0;
      case (state)
         IDLE: cand = accept && HDR_PATTERN[2];
         HDR: begin
            if (hcnt == 2'd2) begin
               cand     = sreg[DATA_W-1];
               eligible = 1'b1;
            end else begin
               cand = HDR_PATTERN[2'd1 - hcnt];
            end
         end
         DATA: begin
            if (sent != PAY_DONE) begin
               cand     = sreg[DATA_W-1];
               eligible = 1'b1;
            end else begin
`ifdef FRAME_TX_PARITY_EN
               cand     = par;
               eligible = 1'b1;
`endif
            end
         end
`ifdef FRAME_TX_PARITY_EN
         PAR: begin
            if (sent == PAY_DONE) begin
               cand     = par;
               eligible = 1'b1;
            end
         end
`endif
         default: ;
      endcase
      active_next = (nstate == HDR) || (nstate == DATA) || (nstate == PAR);
   end

   frame_tx_101_stuffer u_stuffer (
      .clk      (clk),
      .rst      (rst),
      .cand     (cand),
      .eligible (eligible),
      .line_bit (line_bit),
      .stuff    (stuff)
   );

endmodule
